// File: rtl/cmp_share_arbiter.sv
// Four-requester round-robin arbiter sharing a single unsigned comparator.
// Each accepted request takes three cycles: grant, compare, result.
module cmp_share_arbiter #(
  parameter int DATA_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   a_in,
  input  logic [4*DATA_W-1:0]   b_in,
  output logic [3:0]            gnt,
  output logic                  busy,
  output logic                  res_valid,
  output logic [1:0]            res_id,
  output logic                  gt,
  output logic                  eq,
  output logic                  lt,
  output logic [7:0]            cmp_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMP    = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [1:0]        last_w;
  logic [1:0]        win;
  logic              win_found;
  logic              cmp_gt;
  logic              cmp_eq;

  // Round-robin search starting one past the last winner and wrapping.
  always_comb begin
    win       = last_w;
    win_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && req[last_w + 2'(k)]) begin
        win       = last_w + 2'(k);
        win_found = 1'b1;
      end
    end
  end

  // The single shared comparator; "less than" is derived from the other two.
  always_comb begin
    cmp_gt = (op_a > op_b);
    cmp_eq = (op_a == op_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      cmp_count <= '0;
      op_a      <= '0;
      op_b      <= '0;
      last_w    <= 2'd3;
    end else begin
      gnt       <= '0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state  <= CMP;
            busy   <= 1'b1;
            gnt    <= 4'b0001 << win;
            res_id <= win;
            op_a   <= a_in[win*DATA_W +: DATA_W];
            op_b   <= b_in[win*DATA_W +: DATA_W];
            last_w <= win;
          end
        end
        CMP: begin
          gt    <= cmp_gt;
          eq    <= cmp_eq;
          lt    <= ~cmp_gt & ~cmp_eq;
          state <= RESULT;
          busy  <= 1'b1;
        end
        RESULT: begin
          res_valid <= 1'b1;
          cmp_count <= cmp_count + 8'd1;
          state     <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level schedule model.
module tb_cmp_share_arbiter;

  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [4*DW-1:0] a_in;
  logic [4*DW-1:0] b_in;
  logic [3:0]    gnt;
  logic          busy;
  logic          res_valid;
  logic [1:0]    res_id;
  logic          gt;
  logic          eq;
  logic          lt;
  logic [7:0]    cmp_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an edge counter plus the edge numbers at which the next
  // request may be accepted and the pending result is due.
  int         cyc;
  int         accept_at;
  int         res_due;
  int         last_w;
  logic [3:0] e_gnt;
  logic       e_valid;
  logic       e_busy;
  logic [1:0] e_id;
  logic [2:0] e_flags;
  logic [7:0] e_count;

  logic [3:0] r;
  int         grants;
  logic [2:0] exp_flags [4];

  cmp_share_arbiter #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_id    (res_id),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt),
    .cmp_count (cmp_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    cyc       = 0;
    accept_at = 1;
    res_due   = -1;
    last_w    = 3;
    e_gnt     = '0;
    e_valid   = 1'b0;
    e_busy    = 1'b0;
    e_id      = '0;
    e_flags   = '0;
    e_count   = '0;
  endfunction

  function automatic void model_edge();
    int w;
    int av;
    int bv;
    bit found;
    cyc++;
    e_gnt   = '0;
    e_valid = 1'b0;
    if (cyc == res_due) begin
      e_valid = 1'b1;
      e_count = 8'((int'(e_count) + 1) % 256);
    end
    if (cyc >= accept_at && req != 4'b0000) begin
      found = 1'b0;
      w = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && req[(last_w + k) % 4]) begin
          w = (last_w + k) % 4;
          found = 1'b1;
        end
      end
      av = int'(a_in[w*DW +: DW]);
      bv = int'(b_in[w*DW +: DW]);
      e_gnt     = 4'(1 << w);
      e_id      = 2'(w);
      e_flags   = {av > bv, av == bv, av < bv};
      res_due   = cyc + 2;
      accept_at = cyc + 3;
      last_w    = w;
    end
    e_busy = (cyc + 1 < accept_at);
  endfunction

  task automatic checkAll();
    checkOutput("gnt", 32'(gnt), 32'(e_gnt));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("res_valid", 32'(res_valid), 32'(e_valid));
    checkOutput("cmp_count", 32'(cmp_count), 32'(e_count));
    if (e_valid) begin
      checkOutput("res_id", 32'(res_id), 32'(e_id));
      checkOutput("flags", 32'({gt, eq, lt}), 32'(e_flags));
    end
  endtask

  // Drive one cycle of inputs from a negedge, let the edge happen, then check.
  task automatic applyStimulus(input logic [3:0] rq, input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
    req  = rq;
    a_in = a;
    b_in = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_valid", 32'(res_valid), 32'h0);
    checkOutput("reset_id", 32'(res_id), 32'h0);
    checkOutput("reset_flags", 32'({gt, eq, lt}), 32'h0);
    checkOutput("reset_count", 32'(cmp_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    exp_flags[0] = 3'b001;
    exp_flags[1] = 3'b100;
    exp_flags[2] = 3'b010;
    exp_flags[3] = 3'b100;
    @(negedge clk);
    doReset();

    // Single compare from requester 0: A0=01, B0=10 gives lt.
    applyStimulus(4'b0001, 8'b0000_0001, 8'b0000_0010);
    checkOutput("first_gnt", 32'(gnt), 32'h1);
    applyStimulus(4'b0000, 8'b0000_0001, 8'b0000_0010);
    applyStimulus(4'b0000, 8'b0000_0001, 8'b0000_0010);
    checkOutput("first_valid", 32'(res_valid), 32'h1);
    checkOutput("first_id", 32'(res_id), 32'h0);
    checkOutput("first_flags", 32'({gt, eq, lt}), 32'h1);
    checkOutput("first_count", 32'(cmp_count), 32'h1);

    // Operands change right after the grant edge; result must use the old ones.
    applyStimulus(4'b0001, 8'b0000_0011, 8'b0000_0000);
    applyStimulus(4'b0000, 8'b0000_0000, 8'b0000_0011);
    applyStimulus(4'b0000, 8'b0000_0000, 8'b0000_0011);
    checkOutput("latched_flags", 32'({gt, eq, lt}), 32'h4);
    checkOutput("latched_count", 32'(cmp_count), 32'h2);

    // Reset pulsed while the compare is in flight.
    applyStimulus(4'b0001, 8'b0000_0010, 8'b0000_0001);
    checkOutput("abort_busy", 32'(busy), 32'h1);
    doReset();

    // All four requesting: grants 0,1,2,3, one every 3 cycles, each drops on grant.
    r = 4'b1111;
    for (int s = 1; s <= 12; s++) begin
      r = r & ~e_gnt;
      applyStimulus(r, {2'b10, 2'b11, 2'b01, 2'b00}, {2'b01, 2'b11, 2'b00, 2'b01});
      if (s % 3 == 1)
        checkOutput("rr_order", 32'(gnt), 32'(1 << (s / 3)));
      if (s % 3 == 0) begin
        checkOutput("rr_valid", 32'(res_valid), 32'h1);
        checkOutput("rr_id", 32'(res_id), 32'(s / 3 - 1));
        checkOutput("rr_flags", 32'({gt, eq, lt}), 32'(exp_flags[s / 3 - 1]));
      end
    end
    checkOutput("rr_count", 32'(cmp_count), 32'h4);

    // Randomized traffic: bits rise at random, drop on grant or occasionally early.
    r = '0;
    repeat (600) begin
      for (int i = 0; i < 4; i++) begin
        if (r[i] && e_gnt[i])
          r[i] = 1'b0;
        else if (r[i] && $urandom_range(0, 15) == 0)
          r[i] = 1'b0;
        else if (!r[i] && $urandom_range(0, 3) == 0)
          r[i] = 1'b1;
      end
      applyStimulus(r, 8'($urandom), 8'($urandom));
    end

    // Requester 1 alone, held high: 256 compares wrap the counter.
    req = '0;
    doReset();
    grants = 0;
    repeat (768) begin
      applyStimulus(4'b0010, 8'($urandom), 8'($urandom));
      if (gnt == 4'b0010)
        grants++;
    end
    checkOutput("wrap_grants", 32'(grants), 32'd256);
    checkOutput("wrap_count", 32'(cmp_count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
